// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package inst_fetch_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // Fetch FSM: look up the cache, issue a miss request, wait for the fill.
    typedef enum logic [1:0] {
        S_LOOKUP = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT   = 2'd2
    } fetch_state_t;

    // Sequential PC; the add wraps naturally at 32 bits.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: one 32-bit instruction per line.
// Combinational hit/read at the current index, synchronous write at the same index.
module icache_dm
    import inst_fetch_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IDX_W-1:0]          i_idx,
    input  logic [XLEN-IDX_W-3:0]     i_tag,
    input  logic                      i_wr_en,
    input  logic [XLEN-1:0]           i_wr_data,
    output logic                      o_hit,
    output logic [XLEN-1:0]           o_rdata
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [XLEN-1:0]  r_data [LINES];

    // Hit when the indexed line is valid and holds the same tag.
    always_comb begin
        o_hit   = r_valid[i_idx] && (r_tag[i_idx] == i_tag);
        o_rdata = r_data[i_idx];
    end

    // Valid bits: all cleared on reset, set when a line is filled.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_idx] <= 1'b1;
        end
    end

    // Tag and data arrays: written on fill only.
    always_ff @(posedge clk) begin
        // NOTE: the arrays are deliberately not reset; the valid bits alone decide whether a line is usable.
        if (i_wr_en) begin
            r_tag[i_idx]  <= i_tag;
            r_data[i_idx] <= i_wr_data;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: holds the PC, looks it up in a direct-mapped cache,
// fetches misses from the memory controller, and presents {pc, inst, valid}.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int          IDX_W    = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_in,
    input  logic              jump_en,
    input  logic [XLEN-1:0]   jump_target,
    input  logic              mem_busy,
    input  logic              get_inst,
    input  logic [XLEN-1:0]   fetched_pc,
    input  logic [XLEN-1:0]   fetched_inst,
    output logic              if_req_out,
    output logic [XLEN-1:0]   addr_if_out,
    output logic              inst_flush,
    output logic              if_valid_out,
    output logic [XLEN-1:0]   if_pc_out,
    output logic [XLEN-1:0]   if_inst_out
);

    fetch_state_t           r_state;
    logic [XLEN-1:0]        r_pc;
    logic                   r_seen_busy;

    logic                   w_hit;
    logic [XLEN-1:0]        w_line;
    logic                   w_accept;
    logic                   w_fill;
    logic [IDX_W-1:0]       w_idx;
    logic [XLEN-IDX_W-3:0]  w_tag;

    // Cache address split and response acceptance. get_inst is a sticky level
    // from the previous fetch, so a response only counts once mem_busy has
    // been seen high during this wait and has dropped again.
    always_comb begin
        w_idx    = r_pc[IDX_W+1:2];
        w_tag    = r_pc[XLEN-1:IDX_W+2];
        w_accept = (r_state == S_WAIT) && r_seen_busy && !mem_busy &&
                   get_inst && (fetched_pc == r_pc);
        w_fill   = w_accept && !rst;
    end

    icache_dm #(
        .IDX_W (IDX_W)
    ) u_icache (
        .clk       (clk),
        .rst       (rst),
        .i_idx     (w_idx),
        .i_tag     (w_tag),
        .i_wr_en   (w_fill),
        .i_wr_data (fetched_inst),
        .o_hit     (w_hit),
        .o_rdata   (w_line)
    );

    // Fetch FSM with PC and all outputs registered; redirect beats everything but reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_LOOKUP;
            r_pc         <= RESET_PC;
            r_seen_busy  <= 1'b0;
            if_req_out   <= 1'b0;
            addr_if_out  <= ZERO_WORD;
            inst_flush   <= 1'b0;
            if_valid_out <= 1'b0;
            if_pc_out    <= ZERO_WORD;
            if_inst_out  <= ZERO_WORD;
        end else begin
            if_req_out <= 1'b0;
            inst_flush <= 1'b0;
            if (jump_en) begin
                // Abort the memory fetch only if a request is actually outstanding.
                r_pc         <= jump_target;
                r_state      <= S_LOOKUP;
                r_seen_busy  <= 1'b0;
                if_valid_out <= 1'b0;
                inst_flush   <= (r_state == S_WAIT);
            end else begin
                case (r_state)
                    S_LOOKUP: begin
                        if (!stall_in) begin
                            if (w_hit) begin
                                if_valid_out <= 1'b1;
                                if_pc_out    <= r_pc;
                                if_inst_out  <= w_line;
                                r_pc         <= next_pc(r_pc);
                            end else begin
                                if_valid_out <= 1'b0;
                                r_state      <= S_REQ;
                            end
                        end
                    end
                    S_REQ: begin
                        if (!mem_busy) begin
                            if_req_out  <= 1'b1;
                            addr_if_out <= r_pc;
                            r_seen_busy <= 1'b0;
                            r_state     <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (mem_busy) begin
                            r_seen_busy <= 1'b1;
                        end
                        if (w_accept) begin
                            // A stalled fill is left in the cache and delivered by the next lookup.
                            if (!stall_in) begin
                                if_valid_out <= 1'b1;
                                if_pc_out    <= r_pc;
                                if_inst_out  <= fetched_inst;
                                r_pc         <= next_pc(r_pc);
                            end
                            r_state <= S_LOOKUP;
                        end
                    end
                    default: r_state <= S_LOOKUP;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a behavioural memory controller, a
// PC-keyed cache model and expected delivery streams built from plain arithmetic.
module tb_inst_fetch;

    localparam int IDX_W = 6;
    localparam int LINES = 1 << IDX_W;

    logic        clk = 1'b0;
    logic        rst, stall_in, jump_en, mem_busy, get_inst;
    logic [31:0] jump_target, fetched_pc, fetched_inst;
    logic        if_req_out, inst_flush, if_valid_out;
    logic [31:0] addr_if_out, if_pc_out, if_inst_out;

    always #5 clk = ~clk;

    inst_fetch #(.IDX_W(IDX_W), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .jump_en(jump_en),
        .jump_target(jump_target), .mem_busy(mem_busy), .get_inst(get_inst),
        .fetched_pc(fetched_pc), .fetched_inst(fetched_inst),
        .if_req_out(if_req_out), .addr_if_out(addr_if_out), .inst_flush(inst_flush),
        .if_valid_out(if_valid_out), .if_pc_out(if_pc_out), .if_inst_out(if_inst_out)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        int          cyc;
    } deliv_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    deliv_t      got[$];
    int          n_req = 0;
    int          n_flush = 0;
    int          last_req_cyc = 0;
    logic [31:0] last_req_addr = 32'h0;

    logic [31:0] mem_words [logic [31:0]];
    logic [31:0] cm_line   [int];

    // Memory-controller model knobs and state.
    int          m_lat = 5;
    int          m_start_delay = 0;
    bit          m_stale = 0;
    bit          m_ignore_flush = 0;
    bit          m_pending = 0;
    logic [31:0] m_addr = 32'h0;
    int          m_cnt = 0;
    bit          m_responded = 0;

    bit          hook_en = 0;
    logic [31:0] hook_at = 32'h0;
    logic [31:0] hook_to = 32'h0;
    bit          rand_stall = 0;
    bit          rand_lat = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (!mem_words.exists(a)) mem_words[a] = $urandom;
        return mem_words[a];
    endfunction

    // Returns 1 when fetching pc would miss, and records it as cached.
    function automatic int model_fetch(input logic [31:0] pc);
        int idx = int'((pc >> 2) % LINES);
        if (cm_line.exists(idx) && cm_line[idx] == pc) return 0;
        cm_line[idx] = pc;
        return 1;
    endfunction

    // One clock: observe outputs after the edge, then update the memory model and inputs.
    task automatic step();
        bit st;
        bit rs;
        deliv_t d;
        @(posedge clk);
        st = stall_in;
        rs = rst;
        #1;
        cyc++;
        jump_en = 1'b0;
        if (!rs) begin
            if (if_req_out) begin
                n_req++;
                last_req_addr = addr_if_out;
                last_req_cyc = cyc;
            end
            if (inst_flush) n_flush++;
            if (if_valid_out && !st) begin
                d.pc = if_pc_out;
                d.inst = if_inst_out;
                d.cyc = cyc;
                got.push_back(d);
                if (hook_en && if_pc_out == hook_at) begin
                    jump_en = 1'b1;
                    jump_target = hook_to;
                end
            end
        end
        m_responded = 0;
        if (rs) begin
            m_pending = 0;
            mem_busy = 1'b0;
            get_inst = 1'b0;
            fetched_pc = 32'h0;
            fetched_inst = 32'h0;
        end else begin
            if (inst_flush && !m_ignore_flush && m_pending) begin
                m_pending = 0;
                mem_busy = 1'b0;
            end
            if (if_req_out) begin
                if (rand_lat) m_lat = $urandom_range(1, 6);
                m_pending = 1;
                m_addr = addr_if_out;
                m_cnt = m_start_delay + m_lat;
                mem_busy = (m_cnt <= m_lat);
                if (m_stale) begin
                    get_inst = 1'b1;
                    fetched_pc = addr_if_out;
                    fetched_inst = ~word_at(addr_if_out);
                end
            end else if (m_pending) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_pending = 0;
                    mem_busy = 1'b0;
                    get_inst = 1'b1;
                    fetched_pc = m_addr;
                    fetched_inst = word_at(m_addr);
                    m_responded = 1;
                end else begin
                    mem_busy = (m_cnt <= m_lat);
                end
            end
        end
        if (rand_stall) stall_in = ($urandom_range(0, 3) == 0);
    endtask

    task automatic wait_deliveries(input int n, input int budget, output bit ok);
        int k = 0;
        while (got.size() < n && k < budget) begin
            step();
            k++;
        end
        ok = (got.size() >= n);
    endtask

    task automatic wait_req(input int target, input int budget, output bit ok);
        int k = 0;
        while (n_req < target && k < budget) begin
            step();
            k++;
        end
        ok = (n_req >= target);
    endtask

    task automatic test_reset();
        rst = 1'b1; stall_in = 1'b0; jump_en = 1'b0; jump_target = 32'h0;
        mem_busy = 1'b0; get_inst = 1'b0; fetched_pc = 32'h0; fetched_inst = 32'h0;
        step();
        step();
        checks++;
        if ({if_valid_out, if_req_out, inst_flush} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl: valid/req/flush got %b expected 000", {if_valid_out, if_req_out, inst_flush});
        end
        checks++;
        if (if_pc_out !== 32'h0 || if_inst_out !== 32'h0 || addr_if_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: pc=%h inst=%h addr=%h expected all 0", if_pc_out, if_inst_out, addr_if_out);
        end
        rst = 1'b0;
        cm_line.delete();
    endtask

    task automatic test_cold_start();
        int r0 = n_req;
        int exp_miss = 0;
        bit ok;
        m_lat = 5; m_start_delay = 0; m_stale = 0;
        hook_en = 1; hook_at = 32'hC; hook_to = 32'h0;
        got.delete();
        for (int i = 0; i < 4; i++) exp_miss += model_fetch(32'(i * 4));
        wait_deliveries(4, 200, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL cold_timeout: deliveries %0d expected 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++;
            if (got[i].pc !== 32'(i * 4) || got[i].inst !== word_at(32'(i * 4))) begin
                failures++;
                $display("FAIL cold_deliv%0d: pc=%h inst=%h expected pc=%h inst=%h", i, got[i].pc, got[i].inst, i * 4, word_at(32'(i * 4)));
            end
        end
        checks++;
        if (n_req - r0 !== exp_miss) begin failures++; $display("FAIL cold_reqs: got %0d expected %0d", n_req - r0, exp_miss); end
    endtask

    task automatic test_loop();
        int r0 = n_req;
        int exp_miss = 0;
        bit ok;
        got.delete();
        for (int i = 0; i < 4; i++) exp_miss += model_fetch(32'(i * 4));
        wait_deliveries(4, 50, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL loop_timeout: deliveries %0d expected 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++;
            if (got[i].pc !== 32'(i * 4) || got[i].inst !== word_at(32'(i * 4))) begin
                failures++;
                $display("FAIL loop_deliv%0d: pc=%h inst=%h expected pc=%h", i, got[i].pc, got[i].inst, i * 4);
            end
            if (i > 0) begin
                checks++;
                if (got[i].cyc - got[i-1].cyc !== 1) begin
                    failures++;
                    $display("FAIL loop_rate%0d: gap %0d expected 1", i, got[i].cyc - got[i-1].cyc);
                end
            end
        end
        checks++;
        if (n_req - r0 !== exp_miss) begin failures++; $display("FAIL loop_reqs: got %0d expected %0d", n_req - r0, exp_miss); end
    endtask

    task automatic test_redirect_flush();
        int r0;
        int f0 = n_flush;
        int r1;
        bit ok;
        hook_en = 0;
        m_ignore_flush = 1;
        jump_en = 1'b1; jump_target = 32'h10;
        r0 = n_req;
        got.delete();
        wait_req(r0 + 1, 20, ok);
        checks++;
        if (!ok || last_req_addr !== 32'h10) begin
            failures++; $display("FAIL redir_req10: ok=%0d addr=%h expected addr 00000010", ok, last_req_addr);
        end
        step();
        jump_en = 1'b1; jump_target = 32'h100;
        hook_en = 1; hook_at = 32'h100; hook_to = 32'h10;
        wait_deliveries(1, 60, ok);
        void'(model_fetch(32'h100));
        checks++;
        if (!ok || got[0].pc !== 32'h100 || got[0].inst !== word_at(32'h100)) begin
            failures++;
            $display("FAIL redir_first: ok=%0d pc=%h expected 00000100", ok, ok ? got[0].pc : 32'hx);
        end
        checks++;
        if (n_flush - f0 !== 1) begin failures++; $display("FAIL redir_flush: got %0d expected 1", n_flush - f0); end
        checks++;
        if (n_req - r0 !== 2) begin failures++; $display("FAIL redir_reqs: got %0d expected 2", n_req - r0); end
        hook_at = 32'h10; hook_to = 32'h20;
        r1 = n_req;
        wait_deliveries(2, 60, ok);
        checks++;
        if (!ok || got[1].pc !== 32'h10 || got[1].inst !== word_at(32'h10)) begin
            failures++; $display("FAIL redir_line10: ok=%0d expected pc 00000010 refetched", ok);
        end
        checks++;
        if (n_req - r1 !== model_fetch(32'h10)) begin
            failures++; $display("FAIL redir_line10_req: got %0d expected 1", n_req - r1);
        end
        m_ignore_flush = 0;
    endtask

    task automatic test_stall_miss();
        int r0 = n_req;
        int r1;
        int k = 0;
        int rel_cyc;
        bit ok;
        hook_en = 0;
        got.delete();
        wait_req(r0 + 1, 20, ok);
        checks++;
        if (!ok || last_req_addr !== 32'h20) begin
            failures++; $display("FAIL stall_req20: ok=%0d addr=%h expected 00000020", ok, last_req_addr);
        end
        while (!m_responded && k < 30) begin step(); k++; end
        checks++;
        if (!m_responded) begin failures++; $display("FAIL stall_resp_timeout: no response in %0d cycles", k); end
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (if_valid_out !== 1'b0 || if_pc_out !== 32'h10 || if_inst_out !== word_at(32'h10) || got.size() != 0) begin
                failures++;
                $display("FAIL stall_frozen%0d: valid=%b pc=%h expected valid 0 pc 00000010", i, if_valid_out, if_pc_out);
            end
        end
        void'(model_fetch(32'h20));
        stall_in = 1'b0;
        rel_cyc = cyc;
        r1 = n_req;
        hook_en = 1; hook_at = 32'h20; hook_to = 32'h40;
        wait_deliveries(1, 10, ok);
        checks++;
        if (!ok || got[0].pc !== 32'h20 || got[0].inst !== word_at(32'h20) || got[0].cyc !== rel_cyc + 1) begin
            failures++; $display("FAIL stall_deliver: ok=%0d expected pc 00000020 one cycle after release", ok);
        end
        checks++;
        if (n_req - r1 !== model_fetch(32'h20)) begin
            failures++; $display("FAIL stall_noreq: got %0d expected 0", n_req - r1);
        end
    endtask

    task automatic test_stale_get_inst();
        int r0 = n_req;
        bit ok;
        hook_en = 0;
        m_start_delay = 3; m_stale = 1;
        got.delete();
        wait_deliveries(1, 60, ok);
        void'(model_fetch(32'h40));
        checks++;
        if (!ok || got[0].pc !== 32'h40 || got[0].inst !== word_at(32'h40)) begin
            failures++; $display("FAIL stale_deliver: ok=%0d expected pc 00000040 with fresh inst", ok);
        end
        checks++;
        if (ok && got[0].cyc !== last_req_cyc + m_start_delay + m_lat + 1) begin
            failures++;
            $display("FAIL stale_timing: delivered cycle %0d expected %0d", got[0].cyc, last_req_cyc + m_start_delay + m_lat + 1);
        end
        checks++;
        if (n_req - r0 !== 1) begin failures++; $display("FAIL stale_reqs: got %0d expected 1", n_req - r0); end
        m_start_delay = 0; m_stale = 0;
    endtask

    task automatic test_reset_in_wait();
        int r0 = n_req;
        int r1;
        int exp_miss = 0;
        bit ok;
        wait_req(r0 + 1, 20, ok);
        checks++;
        if (!ok || last_req_addr !== 32'h44) begin
            failures++; $display("FAIL rstw_req44: ok=%0d addr=%h expected 00000044", ok, last_req_addr);
        end
        step();
        rst = 1'b1;
        step();
        checks++;
        if ({if_valid_out, if_req_out, inst_flush} !== 3'b000 || if_pc_out !== 32'h0 ||
            if_inst_out !== 32'h0 || addr_if_out !== 32'h0) begin
            failures++;
            $display("FAIL rstw_outputs: valid=%b req=%b flush=%b pc=%h inst=%h addr=%h expected all 0",
                     if_valid_out, if_req_out, inst_flush, if_pc_out, if_inst_out, addr_if_out);
        end
        rst = 1'b0;
        cm_line.delete();
        r1 = n_req;
        got.delete();
        exp_miss = model_fetch(32'h0) + model_fetch(32'h4);
        wait_deliveries(2, 60, ok);
        checks++;
        if (!ok || got[0].pc !== 32'h0 || got[1].pc !== 32'h4 ||
            got[0].inst !== word_at(32'h0) || got[1].inst !== word_at(32'h4)) begin
            failures++; $display("FAIL rstw_restart: ok=%0d expected pcs 0 and 4 from reset pc", ok);
        end
        checks++;
        if (n_req - r1 !== exp_miss) begin failures++; $display("FAIL rstw_invalid: got %0d requests expected %0d", n_req - r1, exp_miss); end
    endtask

    task automatic test_random_stream();
        int r0 = n_req;
        int exp_miss = 0;
        bit ok;
        logic [31:0] exp_pc;
        rand_stall = 1; rand_lat = 1;
        hook_en = 1; hook_at = 32'h23C; hook_to = 32'h200;
        jump_en = 1'b1; jump_target = 32'h200;
        got.delete();
        for (int i = 0; i < 32; i++) exp_miss += model_fetch(32'h200 + 32'((i % 16) * 4));
        wait_deliveries(32, 3000, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rand_timeout: deliveries %0d expected 32", got.size()); end
        for (int i = 0; i < 32 && i < got.size(); i++) begin
            exp_pc = 32'h200 + 32'((i % 16) * 4);
            checks++;
            if (got[i].pc !== exp_pc || got[i].inst !== word_at(exp_pc)) begin
                failures++;
                $display("FAIL rand_deliv%0d: pc=%h inst=%h expected pc=%h inst=%h", i, got[i].pc, got[i].inst, exp_pc, word_at(exp_pc));
            end
        end
        checks++;
        if (n_req - r0 !== exp_miss) begin failures++; $display("FAIL rand_reqs: got %0d expected %0d", n_req - r0, exp_miss); end
        rand_stall = 0; rand_lat = 0; stall_in = 1'b0; m_lat = 5;
    endtask

    task automatic test_wrap();
        logic [31:0] p0 = 32'hFFFF_FFFC;
        logic [31:0] p1;
        bit ok;
        p1 = p0 + 32'd4;
        hook_en = 0;
        jump_en = 1'b1; jump_target = p0;
        got.delete();
        wait_deliveries(2, 60, ok);
        checks++;
        if (!ok || got[0].pc !== p0 || got[0].inst !== word_at(p0)) begin
            failures++; $display("FAIL wrap_last: ok=%0d expected pc %h", ok, p0);
        end
        checks++;
        if (!ok || got[1].pc !== p1 || got[1].inst !== word_at(p1)) begin
            failures++; $display("FAIL wrap_zero: ok=%0d expected pc %h", ok, p1);
        end
    endtask

    initial begin
        test_reset();
        test_cold_start();
        test_loop();
        test_redirect_flush();
        test_stall_miss();
        test_stale_get_inst();
        test_reset_in_wait();
        test_random_stream();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
